// File: rtl/led_frame_scheduler_if.sv
// Request bus from the pattern producers plus the serial LED chain outputs.
interface led_frame_scheduler_if #(parameter int NUM_REQ = 2) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_data;
  logic                  shift_en;
  logic                  latch;
  logic                  busy;
  logic                  frame_done;

  modport master (output req_valid, req_data,
                  input  req_ready, out_data, shift_en, latch, busy, frame_done);
  modport slave  (input  req_valid, req_data,
                  output req_ready, out_data, shift_en, latch, busy, frame_done);
endinterface

// File: rtl/led_frame_scheduler.sv
// Round-robin LED frame scheduler: byte-swapped MSB-first shift, latch pulse, idle refresh.
// Optional BLINK_EN macro adds blink_mask input and periodic masked/forced re-sends.
module led_frame_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int REFRESH_CYCLES = 1024
`ifdef BLINK_EN
  , parameter int BLINK_CYCLES = 4096
`endif
) (
  input logic clk,
  input logic rst,
`ifdef BLINK_EN
  input logic [15:0] blink_mask,
`endif
  led_frame_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] RMAX = (REFRESH_CYCLES > 0) ? CW'(REFRESH_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]    state;
  logic [15:0]   sreg;
  logic [15:0]   last_frame;
  logic [3:0]    bit_cnt;
  logic          out_r;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [CW-1:0] refresh_cnt;
  logic          found;
  logic          any_valid;
  logic          refresh_due;
  logic          refresh_go;
  logic [15:0]   sel_data;
  logic [15:0]   load_src;
  logic [15:0]   masked;
  logic [15:0]   load_frame;

  // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PW:0] idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_data = bus.req_data[15:0];
    for (int i = 1; i < NUM_REQ; i++)
      if (gnt_idx == PW'(i)) sel_data = bus.req_data[16*i +: 16];
  end

  assign any_valid   = |bus.req_valid;
  assign refresh_due = (REFRESH_CYCLES != 0) && (refresh_cnt == RMAX);
  assign load_src    = found ? sel_data : last_frame;

`ifdef BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          force_refresh;

  // A toggle arms a forced re-send; a toggle in the same cycle as a taken refresh re-arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      force_refresh <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt     <= '0;
      blink_phase   <= ~blink_phase;
      force_refresh <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (refresh_go) force_refresh <= 1'b0;
    end
  end

  assign masked     = blink_phase ? (load_src & ~blink_mask) : load_src;
  assign refresh_go = (state == IDLE) && !any_valid && (refresh_due || force_refresh);
`else
  assign masked     = load_src;
  assign refresh_go = (state == IDLE) && !any_valid && refresh_due;
`endif

  assign load_frame = {masked[7:0], masked[15:8]};

  // The first bit is driven straight from the load so bits occupy the 16 SHIFT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      last_frame <= '0;
      bit_cnt    <= '0;
      out_r      <= 1'b0;
      rr_ptr     <= PW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (found || refresh_go) begin
          out_r   <= load_frame[15];
          sreg    <= {load_frame[14:0], 1'b0};
          bit_cnt <= '0;
          state   <= SHIFT;
          if (found) begin
            last_frame <= sel_data;
            rr_ptr     <= gnt_idx;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            state <= LATCH;
          end else begin
            out_r <= sreg[15];
            sreg  <= {sreg[14:0], 1'b0};
          end
        end
        LATCH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != IDLE) refresh_cnt <= '0;
    else if (refresh_cnt != RMAX) refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign bus.out_data   = out_r;
  assign bus.shift_en   = (state == SHIFT);
  assign bus.latch      = (state == LATCH);
  assign bus.frame_done = (state == LATCH);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench: frame table, directed arbitration/refresh/reset sequences, random vs. model.
module tb_led_frame_scheduler;
  localparam int NR = 2;
  localparam int RC = 8;
  typedef logic [NR-1:0]    vld_t;
  typedef logic [16*NR-1:0] dat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_frame_scheduler_if #(.NUM_REQ(NR)) bus ();
  led_frame_scheduler #(.NUM_REQ(NR), .REFRESH_CYCLES(RC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  vld_t o_ready;
  logic o_out, o_se, o_latch, o_busy, o_fd;

  // Reference model: m_t = cycles since a frame started (0 = idle, 1..16 bits, 17 latch).
  int          m_t, m_rr, m_idle;
  logic [15:0] m_sw, m_last;
  logic        m_out;

  typedef struct {
    int          req;
    logic [15:0] data;
    logic [15:0] bits;
  } vec_t;

  function automatic logic [15:0] swap(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic model_reset();
    m_t = 0; m_rr = NR - 1; m_idle = 0; m_sw = '0; m_last = '0; m_out = 1'b0;
  endtask

  function automatic int pick(input vld_t v);
    for (int k = 1; k <= NR; k++)
      if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  // One clock: drive inputs, compare every output to the model, then advance the model.
  task automatic step(input logic r, input vld_t v, input dat_t d);
    vld_t e_ready;
    logic e_se, e_lat, e_busy;
    int   g;
    @(negedge clk);
    rst = r; bus.req_valid = v; bus.req_data = d;
    #1;
    o_ready = bus.req_ready; o_out = bus.out_data; o_se = bus.shift_en;
    o_latch = bus.latch; o_busy = bus.busy; o_fd = bus.frame_done;
    g = pick(v);
    e_ready = '0;
    if (m_t == 0 && g >= 0) e_ready[g] = 1'b1;
    e_se   = (m_t >= 1 && m_t <= 16);
    e_lat  = (m_t == 17);
    e_busy = (m_t != 0);
    chk("model", 32'({o_ready, o_out, o_se, o_latch, o_busy, o_fd}),
                 32'({e_ready, m_out, e_se, e_lat, e_busy, e_lat}));
    if (r) model_reset();
    else if (m_t == 0) begin
      if (g >= 0) begin
        m_last = d[16*g +: 16]; m_sw = swap(m_last); m_rr = g; m_t = 1; m_out = m_sw[15];
      end else if (m_idle >= RC - 1) begin
        m_sw = swap(m_last); m_t = 1; m_out = m_sw[15];
      end else m_idle++;
    end else if (m_t < 16) begin
      m_t++; m_out = m_sw[16 - m_t];
    end else if (m_t == 16) m_t = 17;
    else begin
      m_t = 0; m_idle = 0;
    end
  endtask

  task automatic wait_latch();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, '0, '0);
      if (o_latch) return;
    end
    timeout("wait_latch");
  endtask

  task automatic collect16(output logic [15:0] bits);
    bits = '0;
    for (int b = 0; b < 16; b++) begin
      step(1'b0, '0, '0);
      chk("shift_en", 32'(o_se), 32'(1));
      bits = {bits[14:0], o_out};
    end
  endtask

  initial begin
    vec_t        tbl[5];
    logic [15:0] bits;
    int          gi[4], gc[4], ngr, n, rdy_seen;

    tbl[0] = '{0, 16'hA55A, 16'h5AA5};
    tbl[1] = '{1, 16'h1234, 16'h3412};
    tbl[2] = '{0, 16'h00FF, 16'hFF00};
    tbl[3] = '{1, 16'hABCD, 16'hCDAB};
    tbl[4] = '{0, 16'h8001, 16'h0180};

    bus.req_valid = '0; bus.req_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b0, '0, '0);
    chk("reset_outputs", 32'({o_ready, o_out, o_se, o_latch, o_busy, o_fd}), 32'(0));

    // Table: single frames, back to back at the 18-cycle rate.
    foreach (tbl[i]) begin
      vld_t v;
      dat_t d;
      v = '0; v[tbl[i].req] = 1'b1;
      d = '0; d[16*tbl[i].req +: 16] = tbl[i].data;
      step(1'b0, v, d);
      chk("tbl_grant", 32'(o_ready), 32'(v));
      collect16(bits);
      chk("tbl_bits", 32'(bits), 32'(tbl[i].bits));
      step(1'b0, '0, '0);
      chk("tbl_latch", 32'({o_latch, o_fd, o_se, o_busy}), 32'(4'b1101));
    end

    // Both requesters held valid: grants alternate 18 cycles apart.
    step(1'b1, '0, '0);
    ngr = 0;
    for (int c = 0; c < 200 && ngr < 4; c++) begin
      step(1'b0, 2'b11, {16'hABCD, 16'h1234});
      if (|o_ready) begin
        gi[ngr] = o_ready[1] ? 1 : 0; gc[ngr] = c; ngr++;
      end
    end
    chk("alt_count", 32'(ngr), 32'(4));
    for (int k = 0; k < ngr; k++) chk("alt_grant", 32'(gi[k]), 32'(k % 2));
    for (int k = 1; k < ngr; k++) chk("alt_gap", 32'(gc[k] - gc[k-1]), 32'(18));
    wait_latch();

    // Refresh after RC idle cycles re-sends the last frame without a grant.
    step(1'b0, 2'b01, {16'h0000, 16'h00FF});
    chk("rf_grant", 32'(o_ready), 32'(2'b01));
    wait_latch();
    n = 0; rdy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, '0, '0);
      n++;
      if (|o_ready) rdy_seen = 1;
      if (o_se) break;
    end
    chk("rf_gap", 32'(n), 32'(9));
    chk("rf_no_ready", 32'(rdy_seen), 32'(0));
    bits = {15'b0, o_out};
    for (int b = 1; b < 16; b++) begin
      step(1'b0, '0, '0);
      bits = {bits[14:0], o_out};
    end
    chk("rf_bits", 32'(bits), 32'(16'hFF00));
    step(1'b0, '0, '0);
    chk("rf_latch", 32'(o_latch), 32'(1));

    // Request arriving in the cycle a refresh is due wins.
    repeat (7) step(1'b0, '0, '0);
    step(1'b0, 2'b10, {16'hC3A5, 16'h0000});
    chk("due_grant", 32'(o_ready), 32'(2'b10));
    collect16(bits);
    chk("due_bits", 32'(bits), 32'(16'hA5C3));
    step(1'b0, '0, '0);
    chk("due_latch", 32'(o_latch), 32'(1));

    // Reset during bit 7 aborts the frame; the next refresh sends zeros.
    step(1'b0, 2'b01, {16'h0000, 16'hA55A});
    repeat (7) step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    chk("rst_mid", 32'({o_ready, o_out, o_se, o_latch, o_busy, o_fd}), 32'(0));
    n = 1; rdy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, '0, '0);
      n++;
      if (o_latch) rdy_seen = 1;
      if (o_se) break;
    end
    chk("rst_gap", 32'(n), 32'(9));
    chk("rst_no_latch", 32'(rdy_seen), 32'(0));
    bits = {15'b0, o_out};
    for (int b = 1; b < 16; b++) begin
      step(1'b0, '0, '0);
      bits = {bits[14:0], o_out};
    end
    chk("rst_refresh_bits", 32'(bits), 32'(16'h0000));

    // Random traffic with sparse requests and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      vld_t v;
      v = ($urandom_range(0, 3) == 0) ? vld_t'($urandom) : '0;
      step(($urandom_range(0, 299) == 0), v, dat_t'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
